// File: rtl/vtg_720p_timing.sv
// vtg_720p_timing: raster timing generator for the TMDS output path.
// Produces x/y counters, hsync, vsync, data enable and line/frame strobes,
// all registered and aligned to the x/y shown on the same cycle.
// Optional feature macro VTG_LOCK_GATE_EN: when defined, the raster is gated
// by a synchronized, qualified PLL lock; when undefined, pll_lock is ignored
// and the raster starts on the first edge after reset deasserts.
module vtg_720p_timing #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_lock,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        line_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4095) begin : g_h_total_chk
      $error("vtg_720p_timing: H_TOTAL exceeds 4095");
    end
    if (V_TOTAL > 2047) begin : g_v_total_chk
      $error("vtg_720p_timing: V_TOTAL exceeds 2047");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_lock_chk
      $error("vtg_720p_timing: LOCK_CYCLES must be 1..255");
    end
  endgenerate

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON  = (HS_POL != 0);
  localparam logic        VS_ON  = (VS_POL != 0);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        run_n;
  logic [11:0] x_n;
  logic [10:0] y_n;
  logic        hs_d;
  logic        vs_d;
  logic        de_d;
  logic        fs_d;
  logic        ls_d;

`ifdef VTG_LOCK_GATE_EN
  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_CYCLES);

  logic       lock_meta;
  logic       lock_sync;
  logic [7:0] lock_cnt;
  logic [7:0] lock_cnt_n;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  // Lock qualification counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
    end else begin
      lock_cnt <= lock_cnt_n;
    end
  end

  // Next state: qualify lock in WAIT_LOCK, drop back on any low lock in RUN.
  // The counter sits at LOCK_CYCLES for the cycle that launches RUN and is
  // zero throughout RUN, so every re-entry requalifies from scratch.
  always_comb begin
    state_n    = state;
    lock_cnt_n = '0;
    case (state)
      WAIT_LOCK: begin
        if (lock_sync) begin
          if (lock_cnt == LOCK_TARGET) begin
            state_n = RUN;
          end else begin
            lock_cnt_n = lock_cnt + 8'd1;
          end
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_n = WAIT_LOCK;
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end
`else
  logic unused_pll_lock;
  assign unused_pll_lock = pll_lock;

  // Next state: free-running; only reset returns the block to WAIT_LOCK.
  always_comb begin
    state_n = state;
    case (state)
      WAIT_LOCK: state_n = RUN;
      RUN:       state_n = RUN;
      default:   state_n = RUN;
    endcase
  end
`endif

  // Next raster position: advance while staying in RUN, else start at (0,0).
  always_comb begin
    run_n = (state_n == RUN);
    x_n   = '0;
    y_n   = '0;
    if (run_n && state == RUN) begin
      if (x == H_LAST) begin
        x_n = '0;
        y_n = (y == V_LAST) ? '0 : y + 11'd1;
      end else begin
        x_n = x + 12'd1;
        y_n = y;
      end
    end
  end

  // Next output values, decoded from the next position so that the
  // registered outputs line up with the registered x/y.
  always_comb begin
    hs_d = ~HS_ON;
    vs_d = ~VS_ON;
    de_d = 1'b0;
    fs_d = 1'b0;
    ls_d = 1'b0;
    if (run_n) begin
      de_d = (x_n < H_ACT) && (y_n < V_ACT);
      if ((x_n >= HS_BEG) && (x_n < HS_END)) begin
        hs_d = HS_ON;
      end
      if ((y_n >= VS_BEG) && (y_n < VS_END)) begin
        vs_d = VS_ON;
      end
      ls_d = (x_n == 12'd0);
      fs_d = (x_n == 12'd0) && (y_n == 11'd0);
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      x           <= '0;
      y           <= '0;
      hs          <= ~HS_ON;
      vs          <= ~VS_ON;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      hs          <= hs_d;
      vs          <= vs_d;
      de          <= de_d;
      frame_start <= fs_d;
      line_start  <= ls_d;
      running     <= run_n;
    end
  end

endmodule
